// File: rtl/pipelined_lane_adder.sv
// pipelined_lane_adder: one LANE_W-bit lane resolved per pipeline stage,
// least significant lane first. Per-beat choice of full-width add (carry
// ripples stage to stage) or SIMD add (inter-lane carry killed).
// Global-advance valid/ready flow control: every stage shifts or all hold.
// Optional macro PIPELINED_LANE_ADDER_SAT_EN enables unsigned saturation
// in the last stage; raw carries are still reported.
module pipelined_lane_adder #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic                      in_cin,
  input  logic                      in_simd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum,
  output logic                      out_cout,
  output logic [WIDTH/LANE_W-1:0]   out_lane_carry
);

  localparam int LANES = WIDTH / LANE_W;

  // Stage registers: S(k) holds a beat whose lanes 0..k are resolved.
  logic [LANES-1:0] vld_q;
  logic [WIDTH-1:0] a_q    [LANES];
  logic [WIDTH-1:0] b_q    [LANES];
  logic [WIDTH-1:0] sum_q  [LANES];
  logic [LANES-1:0] lc_q   [LANES];
  logic             simd_q [LANES];
  logic             cout_q;

  // Next-state values for each stage (what it loads when the pipe advances).
  logic [LANES-1:0] vld_d;
  logic [WIDTH-1:0] a_d    [LANES];
  logic [WIDTH-1:0] b_d    [LANES];
  logic [WIDTH-1:0] psum_d [LANES];
  logic [LANES-1:0] plc_d  [LANES];
  logic             simd_d [LANES];
  logic             cin_d  [LANES];
  logic [WIDTH-1:0] sum_d  [LANES];
  logic [LANES-1:0] lc_d   [LANES];
  logic             cout_d;
  logic [LANE_W:0]  lane_res;
  logic             adv;

  // Advance control, stage input selection and per-stage lane add.
  always_comb begin
    adv      = out_ready | ~vld_q[LANES-1];
    lane_res = '0;
    cout_d   = 1'b0;

    vld_d[0]  = in_valid;
    a_d[0]    = in_a;
    b_d[0]    = in_b;
    psum_d[0] = '0;
    plc_d[0]  = '0;
    simd_d[0] = in_simd;
    cin_d[0]  = in_cin & ~in_simd;
    for (int unsigned k = 1; k < LANES; k++) begin
      vld_d[k]  = vld_q[k-1];
      a_d[k]    = a_q[k-1];
      b_d[k]    = b_q[k-1];
      psum_d[k] = sum_q[k-1];
      plc_d[k]  = lc_q[k-1];
      simd_d[k] = simd_q[k-1];
      cin_d[k]  = lc_q[k-1][k-1] & ~simd_q[k-1];
    end

    for (int unsigned k = 0; k < LANES; k++) begin
      lane_res = {1'b0, a_d[k][k*LANE_W +: LANE_W]}
               + {1'b0, b_d[k][k*LANE_W +: LANE_W]}
               + {{LANE_W{1'b0}}, cin_d[k]};
      sum_d[k] = psum_d[k];
      sum_d[k][k*LANE_W +: LANE_W] = lane_res[LANE_W-1:0];
      lc_d[k] = plc_d[k];
      lc_d[k][k] = lane_res[LANE_W];
    end

    cout_d = lc_d[LANES-1][LANES-1] & ~simd_d[LANES-1];

`ifdef PIPELINED_LANE_ADDER_SAT_EN
    // Saturation sits in the last stage so latency is unchanged.
    if (simd_d[LANES-1]) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (lc_d[LANES-1][j]) sum_d[LANES-1][j*LANE_W +: LANE_W] = '1;
      end
    end else if (lc_d[LANES-1][LANES-1]) begin
      sum_d[LANES-1] = '1;
    end
`endif
  end

  // Pipeline registers: reset clears everything, otherwise shift on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      cout_q <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        sum_q[k]  <= '0;
        lc_q[k]   <= '0;
        simd_q[k] <= 1'b0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      cout_q <= cout_d;
      for (int unsigned k = 0; k < LANES; k++) begin
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        sum_q[k]  <= sum_d[k];
        lc_q[k]   <= lc_d[k];
        simd_q[k] <= simd_d[k];
      end
    end
  end

  assign in_ready       = adv;
  assign out_valid      = vld_q[LANES-1];
  assign out_sum        = sum_q[LANES-1];
  assign out_cout       = cout_q;
  assign out_lane_carry = lc_q[LANES-1];

endmodule

// File: tb/tb_pipelined_lane_adder.sv
// Self-checking bench for pipelined_lane_adder (WIDTH=32, LANE_W=8).
// Expected results are queued at acceptance and compared at emission.
module tb_pipelined_lane_adder;

  localparam int WIDTH  = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = WIDTH / LANE_W;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [LANES-1:0] lc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic in_cin = 1'b0;
  logic in_simd = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic out_cout;
  logic [LANES-1:0] out_lane_carry;

  pipelined_lane_adder #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_simd(in_simd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_lane_carry(out_lane_carry)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t next_exp;

  int emits = 0;
  int first_emit = -1;
  int last_emit = -1;
  int first_acc = -1;
  int accepts = 0;

  logic             hold_vld = 1'b0;
  logic [WIDTH-1:0] hold_sum;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic simd);
    exp_t r;
    logic [WIDTH:0] t, am, bm, mask;
    logic [LANE_W:0] ls;
    r = '0;
    if (simd) begin
      for (int j = 0; j < LANES; j++) begin
        ls = {1'b0, a[j*LANE_W +: LANE_W]} + {1'b0, b[j*LANE_W +: LANE_W]};
        r.sum[j*LANE_W +: LANE_W] = ls[LANE_W-1:0];
        r.lc[j] = ls[LANE_W];
`ifdef PIPELINED_LANE_ADDER_SAT_EN
        if (ls[LANE_W]) r.sum[j*LANE_W +: LANE_W] = '1;
`endif
      end
      r.cout = 1'b0;
    end else begin
      for (int j = 0; j < LANES; j++) begin
        mask = ({{WIDTH{1'b0}}, 1'b1} << ((j + 1) * LANE_W)) - 1;
        am = {1'b0, a} & mask;
        bm = {1'b0, b} & mask;
        t = am + bm + {{WIDTH{1'b0}}, cin};
        r.lc[j] = t[(j + 1) * LANE_W];
      end
      t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      r.sum = t[WIDTH-1:0];
      r.cout = t[WIDTH];
`ifdef PIPELINED_LANE_ADDER_SAT_EN
      if (t[WIDTH]) r.sum = '1;
`endif
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold_vld = 1'b0;
    end else begin
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, out_ready | ~out_valid});
      if (hold_vld) begin
        check_eq("stall_hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("stall_hold_sum", {32'd0, out_sum}, {32'd0, hold_sum});
      end
      hold_vld = out_valid & ~out_ready;
      hold_sum = out_sum;
      if (in_valid && in_ready) begin
        sb.push_back(next_exp);
        if (first_acc < 0) first_acc = cyc;
        accepts++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sum", {32'd0, out_sum}, {32'd0, e.sum});
          check_eq("cout", {63'd0, out_cout}, {63'd0, e.cout});
          check_eq("lane_carry", {60'd0, out_lane_carry}, {60'd0, e.lc});
        end
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
        emits++;
      end
    end
  end

  task automatic clr_stats();
    emits = 0; first_emit = -1; last_emit = -1; first_acc = -1; accepts = 0;
  endtask

  // Wait (bounded) until every queued result has been emitted.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq(tag, {32'd0, n < 200}, 64'd1);
  endtask

  // Single beat on an idle pipe; also measures latency in edges.
  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic simd, input exp_t e, input string tag);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_simd = simd; next_exp = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq(tag, n, LANES);
    drain({tag, "_drain"});
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    int bi, i;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check_eq("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check_eq("rst_lane_carry", {60'd0, out_lane_carry}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors with hand-derived results.
    e.sum = 32'h0100_0000; e.cout = 1'b0; e.lc = 4'b0111;
    send_one(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e, "lat_full_chain");
`ifdef PIPELINED_LANE_ADDER_SAT_EN
    e.sum = 32'h00FF_FFFF;
`else
    e.sum = 32'h00FF_FF00;
`endif
    e.cout = 1'b0; e.lc = 4'b0001;
    send_one(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b1, e, "lat_simd_kill");
`ifdef PIPELINED_LANE_ADDER_SAT_EN
    e.sum = 32'hFFFF_FFFF;
`else
    e.sum = 32'h0000_0000;
`endif
    e.cout = 1'b1; e.lc = 4'b1111;
    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, e, "lat_full_ovf");
    e.sum = 32'h0000_00FF; e.cout = 1'b0; e.lc = 4'b0000;
    send_one(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b1, e, "lat_simd_cin_ignored");

    // Backpressure with alternating modes; out_ready low on cycles 2..9.
    clr_stats();
    bi = 0; i = 0;
    while ((bi < 8 || sb.size() != 0 || out_valid) && i < 100) begin
      out_ready = !(i >= 2 && i <= 9);
      if (bi < 8) begin
        ra = $urandom; rb = $urandom; rc = 1'(bi % 3 == 0); rs = 1'(bi % 2);
        if (bi == 1) begin ra = 32'hFFFF_FFFF; rb = 32'h0101_0101; end
        in_a = ra; in_b = rb; in_cin = rc; in_simd = rs;
        next_exp = model(ra, rb, rc, rs);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) bi++;
      @(posedge clk); #1;
      i++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_bounded", {32'd0, i < 100}, 64'd1);
    check_eq("bp_accepts", accepts, 8);
    check_eq("bp_emits", emits, 8);

    // Full throughput: 100 back-to-back random beats.
    clr_stats();
    for (int k = 0; k < 100; k++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      in_a = ra; in_b = rb; in_cin = rc; in_simd = rs;
      next_exp = model(ra, rb, rc, rs);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("tp_drain");
    check_eq("tp_emits", emits, 100);
    check_eq("tp_consecutive", last_emit - first_emit + 1, 100);
    check_eq("tp_first_latency", first_emit - first_acc, LANES);

    // Mid-flight reset: three beats in flight are discarded.
    clr_stats();
    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom;
      in_a = ra; in_b = rb; in_cin = 1'b0; in_simd = 1'b0;
      next_exp = model(ra, rb, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mrst_out_sum", {32'd0, out_sum}, 64'd0);
    check_eq("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (LANES + 2) begin
      @(posedge clk); #1;
      check_eq("mrst_no_ghost", {63'd0, out_valid}, 64'd0);
    end
    ra = 32'h1234_80FF; rb = 32'h0000_8001;
    send_one(ra, rb, 1'b1, 1'b0, model(ra, rb, 1'b1, 1'b0), "mrst_new_beat");
    check_eq("mrst_emits", emits, 1);

    check_eq("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_lane_adder.md
Name: pipelined_lane_adder

Overview:
- Parametrised pipelined adder that processes the operand one LANE_W-bit lane per pipeline stage, least significant lane first.
- Per transaction, it runs in one of two modes:
  - full-width mode: the carry ripples from each lane to the next stage;
  - SIMD mode: lanes are independent and the inter-lane carry is killed.
- It succeeds the fixed 32-bit split adders in the datapath library.
- It adds valid/ready flow control so it can sit directly in streaming datapaths.

Parameters:
- WIDTH, 32, total operand width; must be a multiple of LANE_W.
- LANE_W, 8, lane width; one lane is resolved per stage.
- LANES, WIDTH/LANE_W (derived localparam), pipeline depth and lane count; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in to lane 0; ignored in SIMD mode
- in_simd  input  1  1 = independent lanes, 0 = full-width add
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of the top lane in full mode; 0 in SIMD mode
- out_lane_carry  output  LANES  raw carry-out of each lane, valid in both modes

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, on rst.
- Reset values:
  - all stage valid bits = 0, so out_valid = 0.
  - out_sum = 0, out_cout = 0, out_lane_carry = 0.
  - Operand and carry registers: reset not required; they are don't-care while their stage is invalid.
- Pipeline: LANES register stages, S0..S(LANES-1).
  - Stage k computes lane k: {c_k, sum[k]} = a[k] + b[k] + cin_k.
  - cin_0 = in_cin & ~simd.
  - cin_k = c_(k-1) & ~simd.
  - Upper unprocessed operand lanes, the finished lower sum lanes, the per-lane carries and the simd flag all travel with the beat.
- Latency: exactly LANES cycles from the accepting edge to out_valid = 1, when not stalled.
- Throughput: one beat per cycle when out_ready is held at 1.
- Flow control uses a global advance signal:
  - adv = out_ready | ~out_valid.
  - in_ready = adv. This is combinational from out_ready and out_valid; in_ready does not depend on in_valid.
  - When adv = 1, all stages shift by one.
  - S0 loads the input beat when in_valid & in_ready; otherwise S0 loads a bubble (valid = 0).
  - When adv = 0, every stage holds its contents.
  - Bubbles are not compressed while stalled. This is accepted.
- Output behaviour:
  - out_sum, out_cout and out_lane_carry are registered outputs of the last stage.
  - They stay stable while out_valid = 1 and out_ready = 0.
- Per-transaction mode:
  - in_simd is sampled with its beat.
  - Consecutive beats of different modes are allowed back-to-back with no bubble.
- Arithmetic is modulo 2^LANE_W per lane and modulo 2^WIDTH overall; the carries are reported separately.
- Simultaneous events:
  - Accept and emit in the same cycle is legal; the pipeline stays full.
  - rst has priority over everything. Asserting rst mid-operation discards all in-flight beats.
  - out_valid = 0 on the cycle after rst. in_ready = 1 on the cycle after rst, provided rst has deasserted.
- LANES = 1 degenerates to a single-stage registered adder. In that case SIMD and full mode differ only in cin usage.

Optional Feature:
- Macro: PIPELINED_LANE_ADDER_SAT_EN.
- When defined, the block implements unsigned saturation:
  - SIMD mode: any lane whose c_k = 1 outputs all-ones for that lane.
  - Full mode: if the final carry-out = 1, out_sum = all-ones.
  - Saturation is applied in the last stage, so latency is unchanged.
  - out_cout and out_lane_carry still report the raw carries.
- When undefined: wrap-around results only; no saturation logic is synthesised.

Test Plan:
- Full-width carry chain (WIDTH=32, LANE_W=8), simd=0, cin=0:
  - Stimulus: a=0x00FFFFFF, b=0x00000001.
  - Response after 4 cycles: sum=0x01000000, cout=0, lane_carry=0b0111.
- SIMD carry kill, simd=1, same operands:
  - Response: sum=0x00FFFF00, cout=0, lane_carry=0b0001.
  - With SAT_EN: sum=0x00FFFFFF.
- Full-width overflow, simd=0:
  - Stimulus: a=0xFFFFFFFF, b=0x00000000, cin=1.
  - Response: sum=0x00000000, cout=1.
  - With SAT_EN: sum=0xFFFFFFFF.
- Backpressure and mode mixing:
  - Stimulus: stream 8 beats alternating simd 0/1 with out_ready=0 from cycle 2 to cycle 9.
  - Response: in_ready drops once out_valid=1; no beat is lost or duplicated; results emerge in order and match a golden model; out_sum is stable during the stall.
- Full throughput:
  - Stimulus: out_ready=1, 100 random back-to-back beats.
  - Response: 100 results on 100 consecutive cycles, first at cycle 4.
- Mid-flight reset:
  - Stimulus: 3 beats in flight, assert rst for 1 cycle.
  - Response: the next cycle has out_valid=0 and out_sum=0; none of the 3 beats emerge; a new beat accepted afterwards returns a correct result after 4 cycles.
